// File: rtl/segmented_accumulator_pkg.sv
// Shared types and config helpers for the segmented accumulator and the neuron stage.
package segmented_accumulator_pkg;

  localparam int SEG_DATA_W = 32;
  typedef logic signed [SEG_DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } seg_acc_state_e;

  // Out-of-range group sizes collapse to a single full-width group.
  function automatic int clamp_group(input int g, input int lanes);
    return ((g == 0) || (g > lanes)) ? lanes : g;
  endfunction

  function automatic int clamp_beats(input int b, input int max_beats);
    if (b == 0) return 1;
    if (b > max_beats) return max_beats;
    return b;
  endfunction

endpackage

// File: rtl/seg_acc_reduce.sv
// Combinational lane-to-group reduction: group k sums lanes k*G .. min(k*G+G, LANES)-1.
module seg_acc_reduce #(
  parameter int LANES  = 16,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 44,
  parameter int GW     = 5
) (
  input  logic [LANES-1:0][DATA_W-1:0] data,
  input  logic [GW-1:0]                grp_size,
  output logic [LANES-1:0][ACC_W-1:0]  sums
);

  // Each group is a masked sum over all lanes; groups past the last lane stay zero.
  always_comb begin
    sums = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int i = 0; i < LANES; i++) begin
        if ((i >= k * int'(grp_size)) && (i < (k + 1) * int'(grp_size)))
          sums[k] = sums[k] + ACC_W'(signed'(data[i]));
      end
    end
  end

endmodule

// File: rtl/segmented_accumulator.sv
// Groups, temporally accumulates and saturates input lanes; results compacted on low lanes.
//   state | meaning
//   IDLE  | waiting for first beat; latches G/B and loads accumulators
//   ACCUM | adding further beats until beat_cnt reaches B
//   OUT   | result presented, held until out_ready_i
module segmented_accumulator
  import segmented_accumulator_pkg::*;
#(
  parameter int LANES     = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 256,
  localparam int GW       = $clog2(LANES + 1),
  localparam int BW       = $clog2(MAX_BEATS + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [LANES-1:0][DATA_W-1:0] data_i,
  input  logic [GW-1:0]               cfg_group_i,
  input  logic [BW-1:0]               cfg_beats_i,
  input  logic                        flush_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [LANES-1:0][DATA_W-1:0] data_o,
  output logic [LANES-1:0]            sat_o,
  output logic [GW-1:0]               groups_o
);

  localparam int ACC_W = DATA_W + $clog2(LANES) + $clog2(MAX_BEATS);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  seg_acc_state_e state_q, state_d;

  logic [GW-1:0] grp_q, groups_q, grp_eff, grp_sel, ng_eff;
  logic [BW-1:0] beats_q, beats_eff, beat_cnt_q, beat_cnt_inc;
  logic [LANES-1:0][ACC_W-1:0] acc_q, sums;
  logic do_load, do_add, do_clear;

  assign grp_eff      = GW'(clamp_group(int'(cfg_group_i), LANES));
  assign beats_eff    = BW'(clamp_beats(int'(cfg_beats_i), MAX_BEATS));
  assign grp_sel      = (state_q == IDLE) ? grp_eff : grp_q;
  assign beat_cnt_inc = beat_cnt_q + BW'(1);
  assign groups_o     = groups_q;

  // NG = ceil(LANES/G) without a divider: count groups whose first lane exists.
  always_comb begin
    ng_eff = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k * int'(grp_eff) < LANES) ng_eff = ng_eff + GW'(1);
    end
  end

  seg_acc_reduce #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .GW     (GW)
  ) u_reduce (
    .data     (data_i),
    .grp_size (grp_sel),
    .sums     (sums)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    do_load     = 1'b0;
    do_add      = 1'b0;
    do_clear    = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          do_load = 1'b1;
          state_d = (beats_eff == BW'(1)) ? OUT : ACCUM;
        end
      end
      ACCUM: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          do_add = 1'b1;
          if (beat_cnt_inc == beats_q) state_d = OUT;
        end
      end
      OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over any beat offered in the same cycle.
    if (flush_i) begin
      state_d  = IDLE;
      do_load  = 1'b0;
      do_add   = 1'b0;
      do_clear = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q      <= '0;
      beat_cnt_q <= '0;
      grp_q      <= '0;
      beats_q    <= '0;
      groups_q   <= '0;
    end else if (do_clear) begin
      acc_q      <= '0;
      beat_cnt_q <= '0;
    end else if (do_load) begin
      acc_q      <= sums;
      beat_cnt_q <= BW'(1);
      grp_q      <= grp_eff;
      beats_q    <= beats_eff;
      groups_q   <= ng_eff;
    end else if (do_add) begin
      for (int k = 0; k < LANES; k++) acc_q[k] <= acc_q[k] + sums[k];
      beat_cnt_q <= beat_cnt_inc;
    end
  end

  // Partial sums are hidden; lanes read zero outside OUT.
  always_comb begin
    logic signed [ACC_W-1:0] lane;
    lane   = '0;
    data_o = '0;
    sat_o  = '0;
    if (state_q == OUT) begin
      for (int k = 0; k < LANES; k++) begin
        lane = signed'(acc_q[k]);
        if (lane > SAT_MAX) begin
          data_o[k] = SAT_MAX[DATA_W-1:0];
          sat_o[k]  = 1'b1;
        end else if (lane < SAT_MIN) begin
          data_o[k] = SAT_MIN[DATA_W-1:0];
          sat_o[k]  = 1'b1;
        end else begin
          data_o[k] = lane[DATA_W-1:0];
        end
      end
    end
  end

endmodule
